// File: rtl/circuit_eval_sequencer_pkg.sv
// Shared types and helpers for the LCELL feedback-circuit evaluation sequencer.
package circ_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int N_IN_DEF = 2;
  localparam int N_VEC    = 2 ** N_IN_DEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/circuit_eval_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the clockless circuit output into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/circuit_eval_sequencer.sv
// Walks every input vector of an evolved feedback circuit, samples its settled output
// and accumulates per-vector pass/stability masks plus a fitness score.
module circuit_eval_sequencer
  import circ_eval_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2**N_IN-1:0]    target_i,
  output logic [N_IN-1:0]       dut_inp_o,
  input  logic                  dut_out_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_IN:0]         score_o,
  output logic [2**N_IN-1:0]    pass_mask_o,
  output logic [2**N_IN-1:0]    stable_mask_o
);

  localparam int NV      = 2 ** N_IN;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CW      = clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   LD_SET = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   LD_SMP = CW'(SAMPLES - 1);
  localparam logic [N_IN-1:0] V_LAST = N_IN'(NV - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   v_q, v_d;
  logic [NV-1:0]     tgt_q, tgt_d;
  logic [NV-1:0]     pm_q, pm_d;
  logic [NV-1:0]     sm_q, sm_d;
  logic [N_IN:0]     score_q, score_d;
  logic              ref_q, ref_d;
  logic              pass_q, pass_d;
  logic              stab_q, stab_d;

  logic smp;
  logic first, pass_now, stab_now;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dut_out_i),
    .q_o   (smp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      tgt_q   <= '0;
      pm_q    <= '0;
      sm_q    <= '0;
      score_q <= '0;
      ref_q   <= 1'b0;
      pass_q  <= 1'b0;
      stab_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      tgt_q   <= tgt_d;
      pm_q    <= pm_d;
      sm_q    <= sm_d;
      score_q <= score_d;
      ref_q   <= ref_d;
      pass_q  <= pass_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    tgt_d   = tgt_q;
    pm_d    = pm_q;
    sm_d    = sm_q;
    score_d = score_q;
    ref_d   = ref_q;
    pass_d  = pass_q;
    stab_d  = stab_q;

    // The first sample of a window seeds the reference and restarts both flags.
    first    = (cnt_q == LD_SMP);
    pass_now = (smp == tgt_q[v_q]) & (first | pass_q);
    stab_now = first | (stab_q & (smp == ref_q));

    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      v_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_d = SETTLE;
            cnt_d   = LD_SET;
            v_d     = '0;
            tgt_d   = target_i;
            pm_d    = '0;
            sm_d    = '0;
            score_d = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
            cnt_d   = LD_SMP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SAMPLE: begin
          ref_d  = first ? smp : ref_q;
          pass_d = pass_now;
          stab_d = stab_now;
          if (cnt_q == '0) begin
            pm_d[v_q] = pass_now;
            sm_d[v_q] = stab_now;
            score_d   = score_q + (N_IN+1)'(pass_now);
            if (v_q == V_LAST) begin
              state_d = DONE;
            end else begin
              v_d     = v_q + N_IN'(1);
              state_d = SETTLE;
              cnt_d   = LD_SET;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          v_d     = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dut_inp_o     = v_q;
  assign busy_o        = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done_o        = (state_q == DONE);
  assign score_o       = score_q;
  assign pass_mask_o   = pm_q;
  assign stable_mask_o = sm_q;

endmodule

// File: tb/tb_circuit_eval_sequencer.sv
// Directed bench: NAND-gate circuit model, optional oscillation on vector 2.
module tb_circuit_eval_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] target = 4'h0;
  logic [1:0] dut_inp;
  logic       dut_out;
  logic       busy, done;
  logic [2:0] score;
  logic [3:0] pass_mask, stable_mask;

  logic       toggle_mode = 1'b0;
  logic       tog = 1'b0;
  int         tcnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tcnt == 2) begin
      tcnt <= 0;
      tog  <= ~tog;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  assign dut_out = (toggle_mode && dut_inp == 2'd2) ? tog : ~(dut_inp[0] & dut_inp[1]);

  circuit_eval_sequencer #(
    .N_IN(2), .SETTLE_CYCLES(16), .SAMPLES(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .target_i      (target),
    .dut_inp_o     (dut_inp),
    .dut_out_i     (dut_out),
    .busy_o        (busy),
    .done_o        (done),
    .score_o       (score),
    .pass_mask_o   (pass_mask),
    .stable_mask_o (stable_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at edge 0; done must appear exactly 96 edges later.
  task automatic run_full(input string tag, input logic [3:0] tgt, input bit repulse,
                          input logic [2:0] e_score, input logic [3:0] e_pass,
                          input logic [3:0] e_stab);
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    target = ~tgt;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_score_clr"}, 32'(score), 32'd0);
    for (int e = 1; e <= 96; e++) begin
      if (repulse && e == 30) start = 1'b1;
      step();
      start = 1'b0;
      if (e % 24 == 10) chk({tag, "_dut_inp"}, 32'(dut_inp), 32'(e / 24));
      if (e == 95) begin
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        chk({tag, "_busy_95"}, 32'(busy), 32'd1);
      end
      if (e == 96) begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'(e_score));
        chk({tag, "_pass"}, 32'(pass_mask), 32'(e_pass));
        chk({tag, "_stable"}, 32'(stable_mask), 32'(e_stab));
      end
    end
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_inp_idle"}, 32'(dut_inp), 32'd0);
    chk({tag, "_hold"}, 32'(score), 32'(e_score));
  endtask

  initial begin
    int done_seen;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inp", 32'(dut_inp), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_masks", 32'({pass_mask, stable_mask}), 32'd0);
    #12 rst_n = 1'b1;
    step();

    run_full("nand_ok", 4'b0111, 1'b0, 3'd4, 4'hF, 4'hF);
    run_full("nand_inv", 4'b1000, 1'b0, 3'd0, 4'h0, 4'hF);

    toggle_mode = 1'b1;
    run_full("osc_v2", 4'b0111, 1'b0, 3'd3, 4'hB, 4'hB);
    toggle_mode = 1'b0;

    // Abort while vector 1 is in flight.
    target = 4'b0111;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (39) step();
    chk("abort_pre_inp", 32'(dut_inp), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_inp", 32'(dut_inp), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_score", 32'(score), 32'd1);
    chk("abort_pass", 32'(pass_mask), 32'h1);
    chk("abort_stable", 32'(stable_mask), 32'h1);
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("abort_quiet", 32'(done_seen), 32'd0);
    run_full("after_abort", 4'b0111, 1'b0, 3'd4, 4'hF, 4'hF);

    run_full("restart_ign", 4'b0111, 1'b1, 3'd4, 4'hF, 4'hF);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("st_ab_busy", 32'(busy), 32'd0);
    step();
    chk("st_ab_busy2", 32'(busy), 32'd0);
    chk("st_ab_hold", 32'(score), 32'd4);

    // Asynchronous reset in the middle of vector 2.
    target = 4'b0111;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (49) step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_inp", 32'(dut_inp), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_inp", 32'(dut_inp), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_masks", 32'({pass_mask, stable_mask}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_full("after_rst", 4'b0111, 1'b0, 3'd4, 4'hF, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
